// File: rtl/fifo_write_arbiter.sv
// Round-robin write arbiter in front of a FIFO occupancy tracker.
// One requester at a time owns the write port for a burst of up to MAX_BURST
// words, with one idle cycle between consecutive bursts. The FIFO storage
// belongs to the consumer; this block only tracks the word count and drives
// the write and read enables.
module fifo_write_arbiter #(
  parameter int NREQ      = 4,
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 16,
  parameter int MAX_BURST = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ*WIDTH-1:0]    req_data,
  output logic [NREQ-1:0]          gnt,
  input  logic                     rd_req,
  output logic                     fifo_wr_en,
  output logic [WIDTH-1:0]         fifo_din,
  output logic                     fifo_rd_en,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int IDX_W  = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CNT_W  = $clog2(DEPTH) + 1;
  localparam int BEAT_W = $clog2(MAX_BURST + 1);

  typedef enum logic {IDLE, BURST} state_t;

  state_t              state_q, state_d;
  logic [IDX_W-1:0]    owner_q, owner_d;
  logic [IDX_W-1:0]    last_q, last_d;
  logic [BEAT_W-1:0]   beat_q, beat_d;
  logic [NREQ-1:0]     gnt_q, gnt_d;
  logic [CNT_W-1:0]    count_q;
  logic [IDX_W-1:0]    pick;
  logic                found;

  // Occupancy flags come from the registered count only, so there is no
  // write bypass at full and no read bypass at empty.
  assign full       = (count_q == CNT_W'(DEPTH));
  assign empty      = (count_q == '0);
  assign count      = count_q;
  assign gnt        = gnt_q;
  assign fifo_wr_en = (|(gnt_q & req)) & ~full;
  assign fifo_rd_en = rd_req & ~empty;
  assign fifo_din   = (state_q == BURST) ? req_data[int'(owner_q)*WIDTH +: WIDTH] : '0;

  // Round-robin search: first active request after the last served requester.
  always_comb begin
    pick  = last_q;
    found = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      if (!found && req[(int'(last_q) + k) % NREQ]) begin
        found = 1'b1;
        pick  = IDX_W'((int'(last_q) + k) % NREQ);
      end
    end
  end

  // Burst FSM next-state: grant on the edge after a request, end the burst on
  // request drop or after the last allowed beat; a full FIFO stalls the beat.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    beat_d  = beat_q;
    gnt_d   = gnt_q;
    case (state_q)
      IDLE: begin
        gnt_d = '0;
        if (found && !full) begin
          owner_d = pick;
          gnt_d   = NREQ'(1) << pick;
          beat_d  = '0;
          state_d = BURST;
        end
      end
      BURST: begin
        if (!req[owner_q]) begin
          state_d = IDLE;
          gnt_d   = '0;
          last_d  = owner_q;
        end else if (fifo_wr_en) begin
          beat_d = beat_q + BEAT_W'(1);
          if (beat_q == BEAT_W'(MAX_BURST - 1)) begin
            state_d = IDLE;
            gnt_d   = '0;
            last_d  = owner_q;
          end
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  // Arbiter state registers; reset makes requester 0 the first winner.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      owner_q <= '0;
      last_q  <= IDX_W'(NREQ - 1);
      beat_q  <= '0;
      gnt_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      beat_q  <= beat_d;
      gnt_q   <= gnt_d;
    end
  end

  // Occupancy counter; a simultaneous write and read cancel out.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= '0;
    end else if (fifo_wr_en && !fifo_rd_en) begin
      count_q <= count_q + CNT_W'(1);
    end else if (fifo_rd_en && !fifo_wr_en) begin
      count_q <= count_q - CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Bench for fifo_write_arbiter: directed scenarios with literal expectations
// plus randomized traffic compared every cycle against a behavioural model.
module tb_fifo_write_arbiter;

  localparam int NREQ      = 4;
  localparam int WIDTH     = 8;
  localparam int DEPTH     = 16;
  localparam int MAX_BURST = 4;

  logic                   clk = 1'b0;
  logic                   rst = 1'b0;
  logic [NREQ-1:0]        req = '0;
  logic [NREQ*WIDTH-1:0]  req_data = '0;
  logic                   rd_req = 1'b0;
  logic [NREQ-1:0]        gnt;
  logic                   fifo_wr_en;
  logic [WIDTH-1:0]       fifo_din;
  logic                   fifo_rd_en;
  logic                   full;
  logic                   empty;
  logic [$clog2(DEPTH):0] count;

  int tests = 0;
  int fails = 0;

  fifo_write_arbiter #(
    .NREQ(NREQ), .WIDTH(WIDTH), .DEPTH(DEPTH), .MAX_BURST(MAX_BURST)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .req_data(req_data), .gnt(gnt),
    .rd_req(rd_req), .fifo_wr_en(fifo_wr_en), .fifo_din(fifo_din),
    .fifo_rd_en(fifo_rd_en), .full(full), .empty(empty), .count(count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: who owns the port (-1 = nobody), beats written in
  // the current burst, last served requester, and words held in the FIFO.
  int m_own   = -1;
  int m_beats = 0;
  int m_last  = NREQ - 1;
  int m_count = 0;

  function automatic logic e_full();
    return m_count == DEPTH;
  endfunction
  function automatic logic e_empty();
    return m_count == 0;
  endfunction
  function automatic logic [NREQ-1:0] e_gnt();
    return (m_own < 0) ? '0 : (NREQ'(1) << m_own);
  endfunction
  function automatic logic e_wr();
    return (m_own >= 0) && req[m_own] && !e_full();
  endfunction
  function automatic logic e_rd();
    return rd_req && !e_empty();
  endfunction
  function automatic logic [WIDTH-1:0] e_din();
    return (m_own < 0) ? '0 : req_data[m_own*WIDTH +: WIDTH];
  endfunction

  bit m_wr, m_rd;
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_own = -1; m_beats = 0; m_last = NREQ - 1; m_count = 0;
    end else begin
      m_wr = e_wr();
      m_rd = e_rd();
      if (m_own < 0) begin
        if (req != '0 && !e_full()) begin
          for (int k = 1; k <= NREQ; k++) begin
            if (req[(m_last + k) % NREQ]) begin
              m_own = (m_last + k) % NREQ;
              m_beats = 0;
              break;
            end
          end
        end
      end else if (!req[m_own]) begin
        m_last = m_own;
        m_own  = -1;
      end else if (m_wr) begin
        m_beats++;
        if (m_beats == MAX_BURST) begin
          m_last = m_own;
          m_own  = -1;
        end
      end
      m_count = m_count + int'(m_wr) - int'(m_rd);
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    check("gnt",        gnt,        e_gnt());
    check("fifo_wr_en", fifo_wr_en, e_wr());
    check("fifo_rd_en", fifo_rd_en, e_rd());
    check("fifo_din",   fifo_din,   e_din());
    check("count",      count,      m_count);
    check("full",       full,       e_full());
    check("empty",      empty,      e_empty());
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
      req_data = $urandom();
    end
  endtask

  task automatic do_reset();
    rst = 1'b0; req = '0; rd_req = 1'b0;
    step(1);
    rst = 1'b1;
  endtask

  initial begin
    bit got_full;
    // Reset state
    step(2);
    check("rst_gnt", gnt, 0);
    check("rst_count", count, 0);
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    check("rst_wr_en", fifo_wr_en, 0);
    rst = 1'b1;

    // All four requesting: four bursts of four, one idle cycle between each
    req = 4'b1111;
    for (int k = 1; k <= 20; k++) begin
      step(1);
      check("rr_seq_gnt", gnt, (k % 5 == 0) ? 0 : (64'd1 << (k / 5)));
    end
    check("rr_seq_count", count, 16);
    check("rr_seq_full", full, 1);
    step(3);
    check("idle_at_full_gnt", gnt, 0);

    // Short burst: request dropped after two writes, next search starts at 3
    do_reset();
    req = 4'b0100;
    step(1);
    check("short_gnt", gnt, 4'b0100);
    step(2);
    check("short_count", count, 2);
    req = 4'b0000;
    step(1);
    check("short_drop_gnt", gnt, 0);
    check("short_count_hold", count, 2);
    req = 4'b1111;
    step(1);
    check("short_next_rr", gnt, 4'b1000);

    // Stall at full with grant held, one read lets one more word in
    do_reset();
    req = 4'b0001;
    step(2);
    rd_req = 1'b1;
    step(1);
    rd_req = 1'b0;
    got_full = 1'b0;
    for (int i = 0; i < 40 && !got_full; i++) begin
      step(1);
      got_full = full;
    end
    check("fill_reached_full", got_full, 1);
    check("full_no_write", fifo_wr_en, 0);
    check("full_gnt_held", gnt, 4'b0001);
    step(2);
    check("full_gnt_still", gnt, 4'b0001);
    check("full_count", count, 16);
    rd_req = 1'b1;
    #1;
    check("full_rd_en", fifo_rd_en, 1);
    step(1);
    rd_req = 1'b0;
    check("after_read_count", count, 15);
    check("write_resumes", fifo_wr_en, 1);
    step(1);
    check("refill_count", count, 16);

    // Read of an empty FIFO, then write and read together at count 5
    do_reset();
    rd_req = 1'b1;
    #1;
    check("empty_rd_en", fifo_rd_en, 0);
    step(1);
    check("empty_count", count, 0);
    rd_req = 1'b0;
    req = 4'b0001;
    step(7);
    check("five_count", count, 5);
    rd_req = 1'b1;
    #1;
    check("both_wr", fifo_wr_en, 1);
    check("both_rd", fifo_rd_en, 1);
    step(1);
    rd_req = 1'b0;
    check("both_count", count, 5);

    // Asynchronous reset in the middle of a burst
    do_reset();
    req = 4'b1111;
    step(3);
    #2 rst = 1'b0;
    #1;
    check("async_gnt", gnt, 0);
    check("async_count", count, 0);
    check("async_empty", empty, 1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    req = 4'b0100;
    step(1);
    check("post_rst_gnt", gnt, 4'b0100);

    // Randomized traffic with occasional mid-cycle resets
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 7) == 0) req = NREQ'($urandom());
      rd_req = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 299) == 0) begin
        #2 rst = 1'b0;
        #1;
        step(1);
        rst = 1'b1;
      end else begin
        step(1);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
